// File: rtl/pec_snapshot_streamer.sv
// Performance counter snapshot streamer: latches the counter bank and streams it as one AXI-Stream frame.
// Optional PEC_TIMESTAMP_EN prepends a free-running cycle count as beat 0.
module pec_snapshot_streamer #(
    parameter int NUM_COUNTERS    = 115,
    parameter int COUNTER_WIDTH   = 7,
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int DROP_CNT_WIDTH  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counters_flat,
    input  logic                                  snapshot_req,
    output logic                                  counters_clear,
    output logic                                  busy,
    output logic [DROP_CNT_WIDTH-1:0]             dropped_count,
    output logic [AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast
);

    localparam int TOTAL_BITS = NUM_COUNTERS * COUNTER_WIDTH;
    localparam int NUM_BEATS  = (TOTAL_BITS + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
`ifdef PEC_TIMESTAMP_EN
    localparam int TS_BEATS = 1;
`else
    localparam int TS_BEATS = 0;
`endif
    localparam int FRAME_BEATS = NUM_BEATS + TS_BEATS;
    localparam int SNAP_W      = FRAME_BEATS * AXIS_DATA_WIDTH;
    localparam int BW          = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_BEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e                    state_q, state_d;
    logic [SNAP_W-1:0]         snap_q, snap_d, snap_load;
    logic [BW-1:0]             beat_q, beat_d;
    logic                      clear_q, clear_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
    logic                      hs;

`ifdef PEC_TIMESTAMP_EN
    logic [AXIS_DATA_WIDTH-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + 1'b1;
    end

    always_comb begin
        snap_load = '0;
        snap_load[AXIS_DATA_WIDTH-1:0] = ts_q;
        snap_load[AXIS_DATA_WIDTH +: TOTAL_BITS] = counters_flat;
    end
`else
    always_comb begin
        snap_load = '0;
        snap_load[TOTAL_BITS-1:0] = counters_flat;
    end
`endif

    assign hs = (state_q == SEND) && m_axis_tready;

    // The snapshot is kept as a shift register so the current beat is always the low word.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        beat_d  = beat_q;
        clear_d = 1'b0;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                if (snapshot_req) begin
                    state_d = SEND;
                    snap_d  = snap_load;
                    beat_d  = '0;
                    clear_d = 1'b1;
                end
            end
            SEND: begin
                if (snapshot_req && (drop_q != '1)) begin
                    drop_d = drop_q + 1'b1;
                end
                if (hs) begin
                    snap_d = snap_q >> AXIS_DATA_WIDTH;
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            beat_q  <= '0;
            clear_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            beat_q  <= beat_d;
            clear_q <= clear_d;
            drop_q  <= drop_d;
        end
    end

    assign m_axis_tvalid  = (state_q == SEND);
    assign busy           = (state_q == SEND);
    assign m_axis_tlast   = (state_q == SEND) && (beat_q == LAST_BEAT);
    assign m_axis_tdata   = snap_q[AXIS_DATA_WIDTH-1:0];
    assign counters_clear = clear_q;
    assign dropped_count  = drop_q;

endmodule

// File: doc/pec_snapshot_streamer.md
Name: pec_snapshot_streamer

Overview:
- Reader side of the performance event counter bank.
- On a snapshot request it latches the full flattened counter vector and pulses a clear back to the counter bank.
- It then streams the latched vector as a fixed-length AXI-Stream frame toward the AXI DMA.
- Sits between the counter bank and the DMA S2MM channel of the continuous monitoring system.

Parameters:
- NUM_COUNTERS, 115, number of event counters in the bank.
- COUNTER_WIDTH, 7, width of each counter in bits.
- AXIS_DATA_WIDTH, 64, m_axis_tdata width; any value ≥ 8.
- DROP_CNT_WIDTH, 16, width of the saturating dropped-request counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- counters_flat  input  NUM_COUNTERS*COUNTER_WIDTH  counter i at bits [i*COUNTER_WIDTH +: COUNTER_WIDTH].
- snapshot_req  input  1  single-cycle snapshot request.
- counters_clear  output  1  one-cycle pulse instructing the counter bank to zero its counters.
- busy  output  1  high while a frame is pending or in transfer.
- dropped_count  output  DROP_CNT_WIDTH  number of requests ignored while busy; saturating.
- m_axis_tdata  output  AXIS_DATA_WIDTH  stream data.
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  stream ready.
- m_axis_tlast  output  1  final beat of frame.

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk.
- On a clk edge with rst_n=0, the following clear to 0: state=IDLE, tvalid, tlast, tdata, counters_clear, busy, dropped_count, beat index, snapshot register.
- Reset mid-frame aborts the frame. No tlast is emitted. tvalid is 0 on the cycle after the reset edge.
- TOTAL_BITS = NUM_COUNTERS*COUNTER_WIDTH.
- NUM_BEATS = ceil(TOTAL_BITS/AXIS_DATA_WIDTH). Defaults: 805 bits → 13 beats.
- FSM states: IDLE, SEND.
- IDLE:
  - snapshot_req=1 at an edge latches counters_flat into the snapshot register on that edge and sets beat_idx=0.
  - Next state is SEND. busy, tvalid and counters_clear are all 1 in the following cycle.
  - Latency from req to first tvalid: 1 cycle.
  - counters_clear is high for exactly one cycle per accepted snapshot.
- SEND:
  - tdata = snapshot[beat_idx*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH].
  - Bits beyond TOTAL_BITS read as 0. Defaults: last beat carries bits 768..804; tdata[63:37]=0.
  - tlast = (beat_idx == NUM_BEATS-1).
  - Handshake occurs when tvalid & tready.
    - On handshake, beat_idx increments.
    - On handshake of the tlast beat, next state is IDLE; tvalid and busy are 0 next cycle.
  - While tvalid & !tready, tdata and tlast hold stable. tvalid never drops before handshake.
  - tvalid does not depend combinationally on tready.
- Dropped requests:
  - snapshot_req=1 while state=SEND, including the cycle of the final handshake, is dropped. No latch, no clear pulse.
  - Each dropped request increments dropped_count by 1, saturating at all-ones (0xFFFF by default).
  - dropped_count clears only on reset.
- Back-to-back frames: earliest new acceptance is the cycle after returning to IDLE.
  - Minimum gap between frames with tready=1: 1 idle cycle.
- The snapshot register is unaffected by counters_flat changes after latching.

Optional Feature:
- Macro PEC_TIMESTAMP_EN.
- Defined:
  - A free-running AXIS_DATA_WIDTH-bit cycle counter is added. It resets to 0 and increments every cycle, wrapping to 0.
  - Its value is latched on the same edge as the snapshot.
  - It is emitted as beat 0 of the frame, ahead of the counter beats.
  - Frame length becomes NUM_BEATS+1 (14 by default); tlast moves to the final counter beat.
- Undefined: no timestamp logic; frame is exactly NUM_BEATS beats.

Test Plan:
- Reset checks:
  - Hold rst_n=0 for 3 cycles, then release → tvalid=0, busy=0, counters_clear=0, dropped_count=0.
- Single frame:
  - counter i = i mod 128, tready=1, one req pulse → counters_clear high exactly 1 cycle after req.
  - 13 consecutive beats, each tdata equal to the packed slice; beat 12 upper 27 bits = 0; tlast only on beat 12.
  - busy falls the cycle after beat 12.
- Backpressure:
  - tready pattern 1,0,0,1 repeating during a frame → tdata/tlast stable across stalls.
  - Still exactly 13 handshakes; frame content matches the values latched at req, even if counters_flat changes mid-frame.
- Dropped requests:
  - 3 req pulses during SEND, plus one on the final-handshake cycle → dropped_count=4, no extra clear pulses.
  - 70000 reqs while tready=0 holds the frame → dropped_count=0xFFFF.
- Reset mid-frame:
  - rst_n=0 after beat 5 handshake → tvalid=0 next cycle, no tlast seen.
  - New req after release produces a full 13-beat frame starting at beat 0.
- Timestamp (PEC_TIMESTAMP_EN):
  - req sampled at cycle 100 after reset release → beat 0 tdata=100, then 13 counter beats, tlast on beat 13.
